// File: rtl/prog_fetch_pkg.sv
// Shared constants, state encoding and word packing for the program fetch unit.
// Every prog_fetch source file imports this package.
package prog_fetch_pkg;

    localparam int DEPTH  = 16;
    localparam int AW     = 4;
    localparam int OPC_W  = 4;
    localparam int OPND_W = 4;
    localparam int WORD_W = OPC_W + OPND_W;
    localparam int CNT_W  = AW + 1;

    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(DEPTH);

    localparam logic [1:0] ST_LOAD = 2'd0;
    localparam logic [1:0] ST_IDLE = 2'd1;
    localparam logic [1:0] ST_RUN  = 2'd2;
    localparam logic [1:0] ST_HALT = 2'd3;

    typedef logic [WORD_W-1:0] word_t;

    function automatic word_t pack_word(
        input logic [OPC_W-1:0]  opc,
        input logic [OPND_W-1:0] opnd
    );
        return {opc, opnd};
    endfunction

endpackage

// File: rtl/prog_fetch_mem.sv
// Program store: 16 x 8 words, synchronous write, registered read port.
// The contents have no reset; the read register clears on rst_n.
module prog_mem
    import prog_fetch_pkg::*;
(
    input  logic          clk,
    input  logic          rst_n,
    input  logic          we_i,
    input  logic [AW-1:0] waddr_i,
    input  word_t         wdata_i,
    input  logic          re_i,
    input  logic [AW-1:0] raddr_i,
    output word_t         rdata_o
);

    word_t mem_q [DEPTH];
    word_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    // The read register holds its value whenever no read is requested.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rdata_q <= '0;
        end else if (re_i) begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;

endmodule

// File: rtl/prog_fetch.sv
// Program loader and instruction fetch FSM (LOAD/IDLE/RUN/HALT).
// The read register inside prog_mem drives the fetch outputs.
module prog_fetch
    import prog_fetch_pkg::*;
(
    input  logic              clk,
    input  logic              rst_n,
    input  logic              PC_reset,
    input  logic              mem_write,
    input  logic [OPC_W-1:0]  instr,
    input  logic [OPND_W-1:0] portin,
    input  logic              stall,
    input  logic              jump_en,
    input  logic [AW-1:0]     jump_addr,
    output logic              fetch_valid,
    output logic [OPC_W-1:0]  fetch_instr,
    output logic [OPND_W-1:0] fetch_operand,
    output logic [AW-1:0]     pc,
    output logic [CNT_W-1:0]  load_count,
    output logic              load_full,
    output logic              halted
);

    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] pc_q, pc_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             valid_q, valid_d;
    logic [1:0]       sync_q;
    logic             rst_ok;
    logic             mem_we;
    logic             mem_re;
    word_t            rdata;

    // Reset asserts immediately; release is re-timed to clk first.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= 2'b00;
        end else begin
            sync_q <= {sync_q[0], 1'b1};
        end
    end

    assign rst_ok = sync_q[1];

    always_comb begin
        state_d = state_q;
        pc_d    = pc_q;
        cnt_d   = cnt_q;
        valid_d = valid_q;
        mem_we  = 1'b0;
        mem_re  = 1'b0;
        if (rst_ok) begin
            if (PC_reset) begin
                pc_d    = '0;
                valid_d = 1'b0;
                state_d = ST_IDLE;
                if (mem_write) begin
                    cnt_d   = '0;
                    state_d = ST_LOAD;
                end
            end else if (mem_write) begin
                state_d = ST_LOAD;
                valid_d = 1'b0;
                if (cnt_q < CNT_FULL) begin
                    mem_we = 1'b1;
                    cnt_d  = cnt_q + 1'b1;
                end
            end else begin
                case (state_q)
                    ST_LOAD: state_d = ST_IDLE;
                    ST_IDLE: begin
                        if (cnt_q != '0) begin
                            state_d = ST_RUN;
                        end
                    end
                    ST_RUN: begin
                        if (stall) begin
                            state_d = ST_RUN;
                        end else if (jump_en) begin
                            pc_d    = {1'b0, jump_addr};
                            valid_d = 1'b0;
                        end else if (pc_q >= cnt_q) begin
                            // pc is one bit wider so a full program ends at 16.
                            state_d = ST_HALT;
                            valid_d = 1'b0;
                        end else begin
                            mem_re  = 1'b1;
                            valid_d = 1'b1;
                            pc_d    = pc_q + 1'b1;
                        end
                    end
                    default: state_d = state_q;
                endcase
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= ST_IDLE;
            pc_q    <= '0;
            cnt_q   <= '0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            pc_q    <= pc_d;
            cnt_q   <= cnt_d;
            valid_q <= valid_d;
        end
    end

    prog_mem u_mem (
        .clk     (clk),
        .rst_n   (rst_n),
        .we_i    (mem_we),
        .waddr_i (cnt_q[AW-1:0]),
        .wdata_i (pack_word(instr, portin)),
        .re_i    (mem_re),
        .raddr_i (pc_q[AW-1:0]),
        .rdata_o (rdata)
    );

    assign fetch_valid   = valid_q;
    assign fetch_instr   = rdata[WORD_W-1:OPND_W];
    assign fetch_operand = rdata[OPND_W-1:0];
    assign pc            = pc_q[AW-1:0];
    assign load_count    = cnt_q;
    assign load_full     = (cnt_q == CNT_FULL);
    assign halted        = (state_q == ST_HALT);

endmodule

// File: doc/prog_fetch.md
PROG_FETCH -- requirements
Module: prog_fetch

Interface
REQ-001 clk  input  1  single system clock; all state updates on rising edge.
REQ-002 rst_n  input  1  asynchronous, active-low reset.
REQ-003 PC_reset  input  1  synchronous restart of program counter (active-high).
REQ-004 mem_write  input  1  1 = load mode (write program), 0 = run mode (fetch).
REQ-005 instr  input  4  opcode to be written in load mode.
REQ-006 portin  input  4  operand to be written alongside instr in load mode.
REQ-007 stall  input  1  execute stage not ready; hold fetch outputs and pc.
REQ-008 jump_en  input  1  redirect fetch to jump_addr (run mode only).
REQ-009 jump_addr  input  4  jump target address.
REQ-010 fetch_valid  output  1  fetch_instr/fetch_operand hold a valid word.
REQ-011 fetch_instr  output  4  fetched opcode.
REQ-012 fetch_operand  output  4  fetched operand.
REQ-013 pc  output  4  address of the next word to fetch.
REQ-014 load_count  output  5  number of words loaded, 0..16.
REQ-015 load_full  output  1  high when load_count == 16.
REQ-016 halted  output  1  high in state HALT.

Function
REQ-017 Storage SHALL be 16 entries x 8 bits, entry = {instr, operand}.
REQ-018 States SHALL be LOAD, IDLE, RUN, HALT.
REQ-019 PC_reset=1 SHALL set pc=0, fetch_valid=0, state IDLE; if mem_write=1 in the same cycle it SHALL also clear load_count and enter LOAD, with no write that cycle.
REQ-020 LOAD: each cycle with mem_write=1, PC_reset=0, load_count<16 SHALL write {instr,portin} to entry load_count[3:0] and increment load_count.
REQ-021 LOAD when load_count==16 SHALL ignore writes; load_count saturates at 16, no wrap.
REQ-022 mem_write=1 in any state other than via PC_reset SHALL enter LOAD, drop fetch_valid and append at load_count (no clear).
REQ-023 IDLE -> RUN when mem_write=0, PC_reset=0 and load_count!=0; with load_count==0, IDLE SHALL persist.
REQ-024 RUN, stall=0, jump_en=0: outputs SHALL register mem[pc], fetch_valid=1, pc<=pc+1 (1-cycle read latency).
REQ-025 RUN, stall=1: pc, fetch_valid, fetch_instr, fetch_operand SHALL hold; stall takes priority over jump_en.
REQ-026 RUN, jump_en=1, stall=0: pc<=jump_addr, fetch_valid<=0 for that cycle (flush); fetch resumes next cycle.
REQ-027 RUN: when pc == load_count (end of program) and stall=0, SHALL enter HALT with fetch_valid=0; jump_addr >= load_count SHALL also halt next cycle.
REQ-028 HALT SHALL hold pc and remain until PC_reset or mem_write.
REQ-029 Priority per cycle: rst_n > PC_reset > mem_write > stall > jump_en > sequential fetch.

Reset
REQ-030 rst_n=0 SHALL immediately force state IDLE, pc=0, load_count=0, fetch_valid=0, fetch_instr=0, fetch_operand=0, halted=0.
REQ-031 Memory contents SHALL NOT be reset; entries beyond load_count are never fetched.
REQ-032 rst_n asserted mid-load or mid-run SHALL abort immediately; release SHALL be synchronized to clk before leaving IDLE.

Structure
REQ-033 Shared package SHALL hold state encoding, DEPTH=16, opcode/operand width constants.
REQ-034 Storage SHALL be one sub-module prog_mem (16x8, synchronous write, registered read); FSM and pc live in prog_fetch.

Verification
REQ-035 Load (6,3),(4,0),(6,3),(4,1),(5,0),(8,0),(5,1),(0,0),(7,0),(9,9), then PC_reset with mem_write=0 -> load_count=10; ten valid fetches in order; HALT at pc=10.
REQ-036 Load 17 words -> load_full=1 after 16th; 17th ignored; load_count=16.
REQ-037 During RUN assert stall 3 cycles at pc=4 -> outputs hold word 3, pc stays 4, resume with word 4.
REQ-038 jump_en with jump_addr=2 at pc=6 -> one cycle fetch_valid=0, then word 2, pc=3.
REQ-039 rst_n low mid-run at pc=5 -> all outputs zero same cycle; load_count=0; no fetch after release without reload.
REQ-040 PC_reset with mem_write=1 after a 10-word load, then 2 writes -> load_count=2, run fetches only new words.
